// File: rtl/d_cache_controller_pkg.sv
// Shared geometry, FSM state encodings and line layout for the L1 data-cache controller.
package d_cache_controller_pkg;

    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned BLOCK_BITS = 1024;
    localparam int unsigned NUM_SETS   = 64;

    localparam int unsigned OFFSET_W   = $clog2(BLOCK_BITS / 8);
    localparam int unsigned INDEX_W    = $clog2(NUM_SETS);
    localparam int unsigned TAG_W      = ADDR_W - INDEX_W - OFFSET_W;
    localparam int unsigned WORD_SEL_W = OFFSET_W - 2;
    localparam int unsigned MASK_W     = BLOCK_BITS / 8;

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StLookup  = 3'd1;
    localparam logic [2:0] StMissReq = 3'd2;
    localparam logic [2:0] StResolve = 3'd3;
    localparam logic [2:0] StRespond = 3'd4;

    typedef struct packed {
        logic                  valid;
        logic [TAG_W-1:0]      tag;
        logic [BLOCK_BITS-1:0] data;
    } line_t;

    function automatic logic [31:0] get_word(input logic [BLOCK_BITS-1:0] data,
                                             input logic [WORD_SEL_W-1:0] sel);
        return data[32*sel +: 32];
    endfunction

endpackage

// File: rtl/arbiter_controller_if.sv
// Core/arbiter-facing signal bundle of the data-cache controller.
interface arbiter_controller_if;
    import d_cache_controller_pkg::*;

    logic                  raddr_valid;
    logic [ADDR_W-1:0]     raddr;
    logic                  rdata_valid;
    logic [31:0]           rdata;
    logic                  waddr_valid;
    logic [ADDR_W-1:0]     waddr;
    logic [BLOCK_BITS-1:0] wdata;
    logic [MASK_W-1:0]     wmask;
    logic                  sent_repair;
    logic                  repair_resolved;
    logic                  read_repair_request;
    logic [ADDR_W-1:0]     missed_addr;
    logic                  wdone;

    modport Controller (
        input  raddr_valid, raddr, waddr_valid, waddr, wdata, wmask,
               sent_repair, repair_resolved,
        output rdata_valid, rdata, read_repair_request, missed_addr, wdone
    );

endinterface

// File: rtl/dcache_line_array.sv
// Tag/valid/data storage: one byte-masked write port, one combinational read port.
module dcache_line_array
    import d_cache_controller_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic                  set_tag,
    input  logic [INDEX_W-1:0]    widx,
    input  logic [TAG_W-1:0]      wtag,
    input  logic [BLOCK_BITS-1:0] wdata,
    input  logic [MASK_W-1:0]     wmask,
    input  logic [INDEX_W-1:0]    ridx,
    output line_t                 rline
);

    logic [NUM_SETS-1:0]   valid_q;
    logic [TAG_W-1:0]      tag_q  [NUM_SETS];
    logic [BLOCK_BITS-1:0] data_q [NUM_SETS];

    // Only valid bits are reset; tags and data are don't-care until a fill.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (we && set_tag) begin
            valid_q[widx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (we && set_tag) begin
            tag_q[widx] <= wtag;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < int'(MASK_W); b++) begin
                if (wmask[b]) begin
                    data_q[widx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rline.valid = valid_q[ridx];
    assign rline.tag   = tag_q[ridx];
    assign rline.data  = data_q[ridx];

endmodule

// File: rtl/d_cache_controller.sv
// Direct-mapped blocking L1 data-cache controller: hit service, miss repair request and fill.
module d_cache_controller
    import d_cache_controller_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    arbiter_controller_if.Controller arb
);

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic              wdone_q;

    logic [ADDR_W-1:0] lookup_addr;
    line_t             rline;
    logic              hit;
    logic              store;
    logic              fill;
    logic              we;
    logic              active;

    // In IDLE the single read port serves the store hit check; elsewhere the latched load.
    assign lookup_addr = (state_q == StIdle) ? arb.waddr : addr_q;
    assign hit   = rline.valid && (rline.tag == lookup_addr[ADDR_W-1 -: TAG_W]);
    assign store = (state_q == StIdle) && arb.waddr_valid && !arb.sent_repair;
    assign fill  = (state_q == StMissReq) && arb.waddr_valid && arb.sent_repair;
    assign we    = !rst && ((store && hit) || fill);

    dcache_line_array u_lines (
        .clk     (clk),
        .rst     (rst),
        .we      (we),
        .set_tag (fill),
        .widx    (arb.waddr[OFFSET_W +: INDEX_W]),
        .wtag    (arb.waddr[ADDR_W-1 -: TAG_W]),
        .wdata   (arb.wdata),
        .wmask   (arb.wmask),
        .ridx    (lookup_addr[OFFSET_W +: INDEX_W]),
        .rline   (rline)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:    if (arb.raddr_valid) state_d = StLookup;
            StLookup:  state_d = hit ? StRespond : StMissReq;
            StMissReq: if (fill) state_d = arb.repair_resolved ? StLookup : StResolve;
            StResolve: if (arb.repair_resolved) state_d = StLookup;
            StRespond: state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            addr_q  <= '0;
            wdone_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wdone_q <= store;
            if (state_q == StIdle && arb.raddr_valid) begin
                addr_q <= arb.raddr;
            end
        end
    end

    // Outputs are forced low while reset is held, not just after it is sampled.
    assign active                  = !rst;
    assign arb.rdata_valid         = active && (state_q == StRespond);
    assign arb.rdata               = arb.rdata_valid ?
                                     get_word(rline.data, addr_q[2 +: WORD_SEL_W]) : '0;
    assign arb.read_repair_request = active && (state_q == StMissReq);
    assign arb.missed_addr         = arb.read_repair_request ? addr_q : '0;
    assign arb.wdone               = active && wdone_q;

    logic unused_waddr_offset;
    assign unused_waddr_offset = ^arb.waddr[OFFSET_W-1:0];

endmodule

// File: tb/tb_d_cache_controller.sv
// Scoreboard bench for d_cache_controller: misses, fills, hits, stores and reset abort.
module tb_d_cache_controller;
    import d_cache_controller_pkg::*;

    logic clk;
    logic rst;
    arbiter_controller_if arb ();

    d_cache_controller dut (
        .clk (clk),
        .rst (rst),
        .arb (arb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] sb[$];

    localparam logic [31:0] AddrA = 32'hAABB_CCDD;
    localparam logic [31:0] AddrB = 32'hAABB_CC80;
    localparam logic [31:0] AddrC = 32'h1000_0000;
    localparam logic [31:0] AddrD = 32'h5555_4C80;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [BLOCK_BITS-1:0] pat_nibble();
        logic [BLOCK_BITS-1:0] blk;
        logic [3:0] h;
        for (int i = 0; i < 32; i++) begin
            h = 4'(7 - (i % 8));
            blk[32*i +: 32] = {8{h}};
        end
        return blk;
    endfunction

    function automatic logic [BLOCK_BITS-1:0] pat_base(input logic [31:0] base);
        logic [BLOCK_BITS-1:0] blk;
        for (int i = 0; i < 32; i++) blk[32*i +: 32] = base + 32'(i);
        return blk;
    endfunction

    // Every rdata_valid cycle must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (arb.rdata_valid) begin
            if (sb.size() == 0) check_eq("rdata_unexpected", 32'(arb.rdata_valid), 32'd0);
            else check_eq("rdata", arb.rdata, sb.pop_front());
        end
    end

    task automatic load(input logic [31:0] a);
        arb.raddr_valid = 1'b1;
        arb.raddr       = a;
        @(negedge clk);
        arb.raddr_valid = 1'b0;
    endtask

    task automatic store(input logic [31:0] a, input logic [BLOCK_BITS-1:0] d,
                         input logic [MASK_W-1:0] m);
        arb.waddr_valid = 1'b1;
        arb.sent_repair = 1'b0;
        arb.waddr       = a;
        arb.wdata       = d;
        arb.wmask       = m;
        @(negedge clk);
        arb.waddr_valid = 1'b0;
    endtask

    task automatic fill(input logic [31:0] a, input logic [BLOCK_BITS-1:0] d,
                        input logic resolved_now);
        arb.waddr_valid     = 1'b1;
        arb.sent_repair     = 1'b1;
        arb.waddr           = a;
        arb.wdata           = d;
        arb.wmask           = '1;
        arb.repair_resolved = resolved_now;
        @(negedge clk);
        arb.waddr_valid     = 1'b0;
        arb.sent_repair     = 1'b0;
        arb.repair_resolved = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        check_eq({tag, "_drain"}, 32'(sb.size()), 32'd0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_rdata_valid"}, 32'(arb.rdata_valid), 32'd0);
        check_eq({tag, "_rdata"}, arb.rdata, 32'd0);
        check_eq({tag, "_req"}, 32'(arb.read_repair_request), 32'd0);
        check_eq({tag, "_missed_addr"}, arb.missed_addr, 32'd0);
        check_eq({tag, "_wdone"}, 32'(arb.wdone), 32'd0);
    endtask

    initial begin
        logic [BLOCK_BITS-1:0] blk;

        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [BLOCK_BITS-1:0] blk;

        rst                 = 1'b1;
        arb.raddr_valid     = 1'b0;
        arb.raddr           = '0;
        arb.waddr_valid     = 1'b0;
        arb.waddr           = '0;
        arb.wdata           = '0;
        arb.wmask           = '0;
        arb.sent_repair     = 1'b0;
        arb.repair_resolved = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("post_reset");

        // Cold miss: request appears two cycles after the strobe.
        sb.push_back(32'h0000_0000);
        load(AddrA);
        check_eq("miss_req_early", 32'(arb.read_repair_request), 32'd0);
        @(negedge clk);
        check_eq("miss_req", 32'(arb.read_repair_request), 32'd1);
        check_eq("miss_addr", arb.missed_addr, AddrA);
        repeat (2) @(negedge clk);
        check_eq("miss_req_held", 32'(arb.read_repair_request), 32'd1);

        // Fill, then resolve a few cycles later.
        fill(AddrA, pat_nibble(), 1'b0);
        check_eq("req_dropped", 32'(arb.read_repair_request), 32'd0);
        repeat (2) @(negedge clk);
        check_eq("no_rdata_before_resolve", 32'(sb.size()), 32'd1);
        arb.repair_resolved = 1'b1;
        @(negedge clk);
        arb.repair_resolved = 1'b0;
        wait_drain("fill_a");

        // Hit: rdata_valid exactly at N+2, no request.
        sb.push_back(32'h0000_0000);
        load(AddrA);
        check_eq("hit_early", 32'(arb.rdata_valid), 32'd0);
        @(negedge clk);
        check_eq("hit_valid", 32'(arb.rdata_valid), 32'd1);
        check_eq("hit_no_req", 32'(arb.read_repair_request), 32'd0);
        wait_drain("hit_a");

        // Store hit, word 0 only.
        blk = '0;
        blk[31:0] = 32'hDEAD_BEEF;
        store(AddrB, blk, 128'hF);
        check_eq("wdone_pulse", 32'(arb.wdone), 32'd1);
        @(negedge clk);
        check_eq("wdone_single", 32'(arb.wdone), 32'd0);
        sb.push_back(32'hDEAD_BEEF);
        load(AddrB);
        wait_drain("store_b");
        sb.push_back(32'h6666_6666);
        load(AddrB + 32'd4);
        wait_drain("neighbour_word");

        // Store and load in one cycle: lookup sees the merged word.
        blk = '0;
        blk[95:64] = 32'h1234_5678;
        arb.raddr_valid = 1'b1;
        arb.raddr       = AddrB + 32'd8;
        sb.push_back(32'h1234_5678);
        store(AddrB + 32'd8, blk, 128'hF00);
        arb.raddr_valid = 1'b0;
        wait_drain("store_and_load");
        sb.push_back(32'h1234_5678);
        load(AddrB + 32'd11);
        wait_drain("byte_offset_ignored");

        // Store to an unfilled line is discarded but still acknowledged.
        blk = '0;
        blk[31:0] = 32'hCAFE_BABE;
        store(AddrC, blk, 128'hF);
        check_eq("wdone_miss", 32'(arb.wdone), 32'd1);
        sb.push_back(32'h5A00_0000);
        load(AddrC);
        @(negedge clk);
        check_eq("miss_c_req", 32'(arb.read_repair_request), 32'd1);
        check_eq("miss_c_addr", arb.missed_addr, AddrC);
        load(AddrA);
        check_eq("blocked_load", arb.missed_addr, AddrC);
        fill(AddrC, pat_base(32'h5A00_0000), 1'b1);
        wait_drain("fill_c_same_cycle");

        // Reset during MISS_REQ aborts the miss; the same load misses again.
        load(AddrD);
        @(negedge clk);
        check_eq("miss_d_req", 32'(arb.read_repair_request), 32'd1);
        rst = 1'b1;
        #1;
        check_eq("rst_req", 32'(arb.read_repair_request), 32'd0);
        check_eq("rst_missed_addr", arb.missed_addr, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_idle_outputs("after_abort");
        @(negedge clk);
        sb.push_back(32'hC0DE_0000);
        load(AddrD);
        @(negedge clk);
        check_eq("remiss_d_req", 32'(arb.read_repair_request), 32'd1);
        check_eq("remiss_d_addr", arb.missed_addr, AddrD);
        fill(AddrD, pat_base(32'hC0DE_0000), 1'b1);
        wait_drain("fill_d");

        repeat (3) @(negedge clk);
        check_eq("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/d_cache_controller.md
Name: d_cache_controller

Overview:
- Direct-mapped, blocking L1 data-cache controller holding tag, valid and data arrays.
- Sits between the core load/store path and the memory arbiter.
- Serves reads on hit; on a read miss, requests a block repair from the arbiter and installs the returned block.
- All arbiter-side signals are grouped in interface arbiter_controller_if, and the controller connects through its Controller modport.

Parameters:
- ADDR_W, 32, address width.
- BLOCK_BITS, 1024, line size in bits (128 bytes, 32 words).
- NUM_SETS, 64, number of lines. Index = addr[12:7], offset = addr[6:0], tag = addr[31:13].

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- raddr_valid  in  1  load request strobe (one cycle).
- raddr  in  32  load byte address.
- rdata_valid  out  1  one-cycle pulse; rdata is valid.
- rdata  out  32  loaded word, addr[6:2] selects the word within the line.
- waddr_valid  in  1  write strobe (store or repair fill).
- waddr  in  32  write address.
- wdata  in  1024  write data; word i = wdata[32*i+:32].
- wmask  in  128  byte enables, bit b covers wdata[8*b+:8].
- sent_repair  in  1  qualifies the current write as a miss-repair fill.
- repair_resolved  in  1  arbiter signals that the repair is finished.
- read_repair_request  out  1  miss-repair request, level.
- missed_addr  out  32  full address of the missing load.
- wdone  out  1  one-cycle store acknowledge.

Behaviour:
Reset:
- FSM goes to IDLE.
- All valid bits clear; data and tag arrays are not cleared.
- All outputs are 0.
- Reset mid-operation aborts any pending miss with no fill.

FSM states and transitions:
- IDLE
  - raddr_valid: latch raddr, go to LOOKUP.
  - waddr_valid && !sent_repair (store): on tag hit, merge wdata into the line under wmask; on miss, discard (write-through, no-write-allocate). Pulse wdone next cycle.
  - Read and store in the same cycle: apply the store first, then accept the read; the lookup sees the new data.
- LOOKUP
  - Hit (valid && tag match): go to RESPOND.
  - Miss: go to MISS_REQ.
- MISS_REQ
  - read_repair_request=1 and missed_addr=latched address, held until the fill.
  - First asserted 2 cycles after raddr_valid.
  - On waddr_valid && sent_repair: write wdata under wmask into line waddr[12:7], set tag waddr[31:13], set valid, drop read_repair_request, go to RESOLVE.
- RESOLVE
  - Wait for repair_resolved, then go to LOOKUP (the re-lookup hits).
  - If repair_resolved arrives in the same cycle as the fill, skip the wait.
- RESPOND
  - rdata_valid=1 for one cycle with the selected word, then go to IDLE.

Latency and rules:
- Hit latency: raddr_valid at cycle N, rdata_valid at cycle N+2.
- Blocking: raddr_valid outside IDLE is ignored.
- A store outside IDLE is ignored, except a sent_repair fill in MISS_REQ.
- A fill with sent_repair outside MISS_REQ is ignored.
- Word select uses addr[6:2]; addr[1:0] is ignored for loads.
- A second miss to the same set evicts the old line; there are no dirty lines.

Decomposition:
- CORE_PKG holds: ADDR_W, BLOCK_BITS, NUM_SETS, the index/tag/offset widths, the FSM state enum, and a line struct {valid, tag, data}.
- Interface arbiter_controller_if carries all non-clock/reset ports, with a Controller modport.
- One sub-module, dcache_line_array: the tag/valid/data storage with a byte-masked write port and a combinational read port.

Test Plan:
- Reset, then load 0xAABB_CCDD → read_repair_request=1 and missed_addr=0xAABB_CCDD two cycles later; no rdata_valid.
- Fill: waddr=0xAABB_CCDD, wmask all-ones, sent_repair=1, block with word i = {8{hex(7−i%8)}}; then repair_resolved → rdata_valid pulse, rdata=0x0000_0000 (word 23).
- Load 0xAABB_CCDD again → hit, rdata_valid at N+2, rdata=0x0000_0000, read_repair_request stays 0.
- Store to 0xAABB_CC80 with wdata word0=0xDEAD_BEEF, wmask=0xF, then load 0xAABB_CC80 → rdata=0xDEAD_BEEF, wdone pulses.
- Store to the never-filled line 0x1000_0000, then load it → miss request, no data corruption.
- Assert rst while in MISS_REQ → all outputs 0; a later load of the same address misses again.
